// File: rtl/decoder_nto2n_pipe.sv
// -----------------------------------------------------------------------------
// decoder_nto2n_pipe
//
// Registered binary-to-one-hot decoder with a valid/ready handshake on both
// sides. A code is either taken from in_sel (DIRECT mode) or from an internal
// scan pointer (SCAN mode). The decoded vector is held in a single output
// register stage that downstream backpressure can stall. The output polarity
// is selectable.
//
// Parameters:
//   IN_W        width of the binary select input
//   OUT_N       number of decoded outputs, 1 <= OUT_N <= 2**IN_W
//   ACTIVE_LOW  0: selected bit is 1, others 0; 1: selected bit is 0, others 1
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         load enable; low blocks every new transfer
//   mode       0 = DIRECT (decode in_sel), 1 = SCAN (decode the scan pointer)
//   in_valid   in_sel is valid (only looked at in DIRECT mode)
//   in_ready   block can accept or generate a code this cycle
//   in_sel     binary code to decode
//   out_valid  out_dec / out_idx / out_err hold a valid result
//   out_ready  downstream consumes the result
//   out_dec    decoded vector, polarity set by ACTIVE_LOW
//   out_idx    registered copy of the decoded code
//   out_err    registered result had a code >= OUT_N
//   scan_wrap  one-cycle pulse after the scan pointer wraps to 0
// -----------------------------------------------------------------------------
module decoder_nto2n_pipe #(
   parameter int IN_W       = 3,
   parameter int OUT_N      = 8,
   parameter int ACTIVE_LOW = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_N-1:0]  out_dec,
   output logic [IN_W-1:0]   out_idx,
   output logic              out_err,
   output logic              scan_wrap
);

   // Vector driven whenever no output is selected (idle, drained or error).
   localparam logic [OUT_N-1:0] INACTIVE   = (ACTIVE_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

   // Level driven on the single selected output bit.
   localparam logic             ACTIVE_BIT = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

   // OUT_N widened by one bit so the range check also covers OUT_N == 2**IN_W.
   localparam logic [IN_W:0]    OUT_N_EXT  = (IN_W + 1)'(OUT_N);

   // Highest legal code; the scan pointer wraps after decoding this value.
   localparam logic [IN_W-1:0]  LAST_CODE  = IN_W'(OUT_N - 1);

   logic              accept;
   logic              scan_accept;
   logic              drain;
   logic              ptr_at_last;
   logic              code_err;
   logic [IN_W-1:0]   code;
   logic [IN_W-1:0]   scan_ptr;
   logic [OUT_N-1:0]  dec_next;

   // Handshake. The output register is a plain pass-through stage without a
   // skid buffer, so it can only take a new code when it is empty or is being
   // emptied this same cycle. In SCAN mode the block sources its own codes,
   // so in_valid is irrelevant and readiness alone is an accept.
   always_comb begin
      in_ready    = en & (~out_valid | out_ready);
      accept      = in_ready & (mode | in_valid);
      scan_accept = accept & mode;
      drain       = out_valid & out_ready;
   end

   // Code selection and range check. The scan pointer never leaves the legal
   // range, so code_err can only be set by an out-of-range DIRECT select.
   always_comb begin
      code        = mode ? scan_ptr : in_sel;
      code_err    = ({1'b0, code} >= OUT_N_EXT);
      ptr_at_last = (scan_ptr == LAST_CODE);
   end

   // One-hot decode of the selected code. Codes with no matching output bit
   // simply leave the whole vector inactive, which is the error result.
   always_comb begin
      dec_next = INACTIVE;
      for (int i = 0; i < OUT_N; i++) begin
         if (code == IN_W'(i)) begin
            dec_next[i] = ACTIVE_BIT;
         end
      end
   end

   // Output register stage. An accept always wins over a drain, which gives
   // back-to-back replacement at one transfer per cycle. Without an accept
   // or drain the stage holds, which keeps the result stable under
   // backpressure. out_dec is returned to inactive when the stage empties,
   // so an empty stage never shows a selected bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_dec   <= INACTIVE;
         out_idx   <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_dec   <= dec_next;
         out_idx   <= code;
         out_err   <= code_err;
      end else if (drain) begin
         out_valid <= 1'b0;
         out_dec   <= INACTIVE;
         out_err   <= 1'b0;
      end
   end

   // Scan pointer. It advances only on a SCAN accept, so it holds through
   // DIRECT periods, en=0 and backpressure. The wrap pulse is registered
   // alongside the result of the last legal code, so it lines up with the
   // cycle in which that code is presented on out_idx.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_ptr  <= '0;
         scan_wrap <= 1'b0;
      end else begin
         scan_wrap <= 1'b0;
         if (scan_accept) begin
            if (ptr_at_last) begin
               scan_ptr  <= '0;
               scan_wrap <= 1'b1;
            end else begin
               scan_ptr  <= scan_ptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_decoder_nto2n_pipe.sv
// -----------------------------------------------------------------------------
// tb_decoder_nto2n_pipe
//
// Drives three decoder configurations from the same stimulus:
//   c0: IN_W=3 OUT_N=8 ACTIVE_LOW=0
//   c1: IN_W=3 OUT_N=6 ACTIVE_LOW=0
//   c2: IN_W=3 OUT_N=8 ACTIVE_LOW=1
// A cycle-level reference model tracks what each configuration must show.
// Directed vectors with constant expectations cover the main scenarios, and
// a randomized run is compared against the model.
// -----------------------------------------------------------------------------
module tb_decoder_nto2n_pipe;

   localparam int IN_W = 3;
   localparam int NCFG = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            mode;
   logic            in_valid;
   logic [IN_W-1:0] in_sel;
   logic            out_ready;

   logic            rdy0, rdy1, rdy2;
   logic            val0, val1, val2;
   logic [7:0]      dec0;
   logic [5:0]      dec1;
   logic [7:0]      dec2;
   logic [2:0]      idx0, idx1, idx2;
   logic            err0, err1, err2;
   logic            wrap0, wrap1, wrap2;

   logic            dut_rdy  [NCFG];
   logic            dut_val  [NCFG];
   logic [7:0]      dut_dec  [NCFG];
   logic [2:0]      dut_idx  [NCFG];
   logic            dut_err  [NCFG];
   logic            dut_wrap [NCFG];

   int              checks = 0;
   int              errors = 0;

   // Reference model state, one entry per configuration.
   bit              m_valid [NCFG];
   int              m_idx   [NCFG];
   bit              m_err   [NCFG];
   int              m_ptr   [NCFG];
   bit              m_wrap  [NCFG];

   logic            last_rdy0;

   always #5 clk = ~clk;

   decoder_nto2n_pipe #(.IN_W(3), .OUT_N(8), .ACTIVE_LOW(0)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
      .in_ready(rdy0), .in_sel(in_sel), .out_valid(val0), .out_ready(out_ready),
      .out_dec(dec0), .out_idx(idx0), .out_err(err0), .scan_wrap(wrap0)
   );

   decoder_nto2n_pipe #(.IN_W(3), .OUT_N(6), .ACTIVE_LOW(0)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
      .in_ready(rdy1), .in_sel(in_sel), .out_valid(val1), .out_ready(out_ready),
      .out_dec(dec1), .out_idx(idx1), .out_err(err1), .scan_wrap(wrap1)
   );

   decoder_nto2n_pipe #(.IN_W(3), .OUT_N(8), .ACTIVE_LOW(1)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
      .in_ready(rdy2), .in_sel(in_sel), .out_valid(val2), .out_ready(out_ready),
      .out_dec(dec2), .out_idx(idx2), .out_err(err2), .scan_wrap(wrap2)
   );

   assign dut_rdy[0]  = rdy0;  assign dut_rdy[1]  = rdy1;  assign dut_rdy[2]  = rdy2;
   assign dut_val[0]  = val0;  assign dut_val[1]  = val1;  assign dut_val[2]  = val2;
   assign dut_dec[0]  = dec0;  assign dut_dec[1]  = {2'b00, dec1};  assign dut_dec[2] = dec2;
   assign dut_idx[0]  = idx0;  assign dut_idx[1]  = idx1;  assign dut_idx[2]  = idx2;
   assign dut_err[0]  = err0;  assign dut_err[1]  = err1;  assign dut_err[2]  = err2;
   assign dut_wrap[0] = wrap0; assign dut_wrap[1] = wrap1; assign dut_wrap[2] = wrap2;

   typedef struct {
      bit         en;
      bit         mode;
      bit         in_valid;
      logic [2:0] sel;
      bit         ordy;
      bit         exp_rdy;
      bit         exp_valid;
      logic [2:0] exp_idx;
      logic [7:0] exp_dec;
   } vec_t;

   vec_t vecs[$];

   function automatic int cfg_n(int c);
      return (c == 1) ? 6 : 8;
   endfunction

   function automatic bit cfg_al(int c);
      return (c == 2);
   endfunction

   function automatic bit model_ready(int c);
      return en && (!m_valid[c] || out_ready);
   endfunction

   // Expected output vector: one selected position counted from bit 0,
   // nothing selected when empty or out of range, inverted for active-low.
   function automatic logic [7:0] model_dec(int c);
      logic [7:0] v;
      logic [7:0] mask;
      mask = 8'((1 << cfg_n(c)) - 1);
      if (!m_valid[c] || m_idx[c] >= cfg_n(c)) v = 8'h00;
      else                                     v = 8'(1 << m_idx[c]);
      if (cfg_al(c)) v = ~v;
      return v & mask;
   endfunction

   function automatic vec_t mk(bit e, bit m, bit iv, logic [2:0] s, bit o,
                               bit er, bit ev, logic [2:0] ei, logic [7:0] ed);
      vec_t v;
      v.en = e; v.mode = m; v.in_valid = iv; v.sel = s; v.ordy = o;
      v.exp_rdy = er; v.exp_valid = ev; v.exp_idx = ei; v.exp_dec = ed;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCFG; c++) begin
         m_valid[c] = 0; m_idx[c] = 0; m_err[c] = 0; m_ptr[c] = 0; m_wrap[c] = 0;
      end
   endtask

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      for (int c = 0; c < NCFG; c++) begin
         bit acc;
         int code;
         acc = model_ready(c) && (mode || in_valid);
         m_wrap[c] = 0;
         if (rst) begin
            m_valid[c] = 0; m_idx[c] = 0; m_err[c] = 0; m_ptr[c] = 0;
         end else if (acc) begin
            code       = mode ? m_ptr[c] : int'(in_sel);
            m_valid[c] = 1;
            m_idx[c]   = code;
            m_err[c]   = (code >= cfg_n(c));
            if (mode) begin
               m_ptr[c]  = (m_ptr[c] + 1) % cfg_n(c);
               m_wrap[c] = (m_ptr[c] == 0);
            end
         end else if (m_valid[c] && out_ready) begin
            m_valid[c] = 0;
         end
      end
   endtask

   task automatic checkOutput();
      for (int c = 0; c < NCFG; c++) begin
         check($sformatf("c%0d_out_valid", c), 32'(dut_val[c]),  32'(m_valid[c]));
         check($sformatf("c%0d_out_dec", c),   32'(dut_dec[c]),  32'(model_dec(c)));
         check($sformatf("c%0d_scan_wrap", c), 32'(dut_wrap[c]), 32'(m_wrap[c]));
         if (m_valid[c]) begin
            check($sformatf("c%0d_out_idx", c), 32'(dut_idx[c]), 32'(m_idx[c]));
            check($sformatf("c%0d_out_err", c), 32'(dut_err[c]), 32'(m_err[c]));
         end
      end
   endtask

   // One full cycle: drive at the falling edge, check the combinational
   // ready, let the rising edge happen, then check the registered outputs.
   task automatic applyStimulus(input bit r, input bit e, input bit m, input bit iv,
                                input logic [2:0] s, input bit o);
      @(negedge clk);
      rst = r; en = e; mode = m; in_valid = iv; in_sel = s; out_ready = o;
      #1;
      last_rdy0 = rdy0;
      for (int c = 0; c < NCFG; c++) begin
         check($sformatf("c%0d_in_ready", c), 32'(dut_rdy[c]), 32'(model_ready(c)));
      end
      @(posedge clk);
      model_step();
      #1;
      checkOutput();
   endtask

   initial begin
      vec_t v;

      rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset state.
      applyStimulus(1, 0, 0, 0, 3'd0, 0);
      check("reset_valid",  32'(val0),  32'd0);
      check("reset_dec_al", 32'(dec2),  32'hFF);
      check("reset_dec",    32'(dec0),  32'h00);
      check("reset_idx",    32'(idx0),  32'd0);
      check("reset_err",    32'(err0),  32'd0);
      check("reset_wrap",   32'(wrap0), 32'd0);

      // Directed table for the 8-output active-high configuration:
      // DIRECT sweep, backpressure hold, release, drain, en=0.
      vecs.push_back(mk(1, 0, 1, 3'd0, 1, 1, 1, 3'd0, 8'h01));
      vecs.push_back(mk(1, 0, 1, 3'd1, 1, 1, 1, 3'd1, 8'h02));
      vecs.push_back(mk(1, 0, 1, 3'd2, 1, 1, 1, 3'd2, 8'h04));
      vecs.push_back(mk(1, 0, 1, 3'd3, 1, 1, 1, 3'd3, 8'h08));
      vecs.push_back(mk(1, 0, 1, 3'd4, 1, 1, 1, 3'd4, 8'h10));
      vecs.push_back(mk(1, 0, 1, 3'd5, 1, 1, 1, 3'd5, 8'h20));
      vecs.push_back(mk(1, 0, 1, 3'd6, 1, 1, 1, 3'd6, 8'h40));
      vecs.push_back(mk(1, 0, 1, 3'd7, 1, 1, 1, 3'd7, 8'h80));
      vecs.push_back(mk(1, 0, 1, 3'd3, 1, 1, 1, 3'd3, 8'h08));
      for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 1, 3'd6, 0, 0, 1, 3'd3, 8'h08));
      vecs.push_back(mk(1, 0, 1, 3'd6, 1, 1, 1, 3'd6, 8'h40));
      vecs.push_back(mk(1, 0, 0, 3'd1, 1, 1, 0, 3'd0, 8'h00));
      vecs.push_back(mk(1, 0, 0, 3'd1, 0, 1, 0, 3'd0, 8'h00));
      vecs.push_back(mk(0, 0, 1, 3'd2, 1, 0, 0, 3'd0, 8'h00));
      vecs.push_back(mk(0, 1, 1, 3'd2, 1, 0, 0, 3'd0, 8'h00));

      for (int k = 0; k < vecs.size(); k++) begin
         v = vecs[k];
         applyStimulus(0, v.en, v.mode, v.in_valid, v.sel, v.ordy);
         check($sformatf("vec%0d_in_ready", k),  32'(last_rdy0), 32'(v.exp_rdy));
         check($sformatf("vec%0d_out_valid", k), 32'(val0),      32'(v.exp_valid));
         check($sformatf("vec%0d_out_dec", k),   32'(dec0),      32'(v.exp_dec));
         if (v.exp_valid) check($sformatf("vec%0d_out_idx", k), 32'(idx0), 32'(v.exp_idx));
      end

      // Out-of-range codes on the 6-output configuration.
      applyStimulus(0, 1, 0, 1, 3'd6, 1);
      check("n6_sel6_dec", 32'(dec1), 32'h00);
      check("n6_sel6_err", 32'(err1), 32'd1);
      check("n6_sel6_val", 32'(val1), 32'd1);
      applyStimulus(0, 1, 0, 1, 3'd7, 1);
      check("n6_sel7_dec", 32'(dec1), 32'h00);
      check("n6_sel7_err", 32'(err1), 32'd1);
      applyStimulus(0, 1, 0, 1, 3'd2, 1);
      check("n6_sel2_dec", 32'(dec1), 32'h04);
      check("n6_sel2_err", 32'(err1), 32'd0);

      // Active-low polarity and drain back to all-inactive.
      applyStimulus(0, 1, 0, 1, 3'd5, 1);
      check("al_sel5_dec", 32'(dec2), 32'hDF);
      applyStimulus(0, 1, 0, 0, 3'd5, 1);
      check("al_drain_dec", 32'(dec2), 32'hFF);
      check("al_drain_val", 32'(val2), 32'd0);

      // SCAN sweep with wrap pulses.
      applyStimulus(1, 0, 0, 0, 3'd0, 0);
      for (int k = 0; k < 14; k++) begin
         applyStimulus(0, 1, 1, 0, 3'd0, 1);
         check($sformatf("scan%0d_idx_n6", k),  32'(idx1),  32'(k % 6));
         check($sformatf("scan%0d_wrap_n6", k), 32'(wrap1), 32'((k % 6) == 5));
         check($sformatf("scan%0d_idx_n8", k),  32'(idx0),  32'(k % 8));
         check($sformatf("scan%0d_err_n6", k),  32'(err1),  32'd0);
      end

      // Mode switching keeps the pointer; reset clears it; en=0 freezes it.
      applyStimulus(1, 0, 0, 0, 3'd0, 0);
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 3'd0, 1);
      check("mix_scan_idx", 32'(idx0), 32'd2);
      applyStimulus(0, 1, 0, 1, 3'd7, 1);
      check("mix_direct_a", 32'(idx0), 32'd7);
      applyStimulus(0, 1, 0, 1, 3'd4, 1);
      check("mix_direct_b", 32'(idx0), 32'd4);
      applyStimulus(0, 1, 1, 0, 3'd0, 1);
      check("mix_resume_n8", 32'(idx0), 32'd3);
      check("mix_resume_n6", 32'(idx1), 32'd3);
      applyStimulus(1, 1, 1, 0, 3'd0, 1);
      check("mix_rst_val",    32'(val0), 32'd0);
      check("mix_rst_dec",    32'(dec0), 32'h00);
      check("mix_rst_dec_al", 32'(dec2), 32'hFF);
      applyStimulus(0, 1, 1, 0, 3'd0, 1);
      check("mix_after_rst_idx", 32'(idx0), 32'd0);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 1, 3'd5, 1);
      check("mix_en0_val", 32'(val0), 32'd0);
      applyStimulus(0, 1, 1, 0, 3'd0, 1);
      check("mix_en1_idx", 32'(idx0), 32'd1);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 600; k++) begin
         applyStimulus(($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 7) != 0),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
